// File: rtl/preg_reclaim_queue_if.sv
// Push/release bundle between ROB commit/recovery, the reclaim queue and the free list.
// The master side drives retire/squash releases; the slave side is the reclaim queue.
interface preg_reclaim_queue_if #(
  parameter int PW = 6
);
  logic [1:0]    commit_valid;
  logic [1:0]    commit_has_dest;
  logic [PW-1:0] commit_old_phys0;
  logic [PW-1:0] commit_old_phys1;
  logic          squash_valid;
  logic [PW-1:0] squash_phys;
  logic          in_ready;
  logic          free_en;
  logic [PW-1:0] free_phys;

  modport master (
    output commit_valid, commit_has_dest, commit_old_phys0, commit_old_phys1,
    output squash_valid, squash_phys,
    input  in_ready, free_en, free_phys
  );

  modport slave (
    input  commit_valid, commit_has_dest, commit_old_phys0, commit_old_phys1,
    input  squash_valid, squash_phys,
    output in_ready, free_en, free_phys
  );
endinterface

// File: rtl/preg_reclaim_queue.sv
// Buffers freed physical registers (2 retire lanes + 1 squash per cycle) and releases one per cycle.
// Optional RECLAIM_DUPCHK_EN adds a pending mask and a sticky dup_err for double releases.
module preg_reclaim_queue #(
  parameter int PHYS_REGS = 64,
  parameter int QDEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  preg_reclaim_queue_if.slave      bus,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic                     overflow_err
`ifdef RECLAIM_DUPCHK_EN
  ,
  output logic                     dup_err
`endif
);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_THREE = {{(CW-2){1'b0}}, 2'b11};
  localparam logic [CW-1:0] CNT_DEPTH = CW'(QDEPTH);

  logic [PW-1:0] mem_r [QDEPTH];
  logic [AW:0]   head_r;
  logic [AW:0]   tail_r;
  logic [CW-1:0] count_r;
  logic          free_en_r;
  logic [PW-1:0] free_phys_r;
  logic          overflow_r;

  logic [2:0]    cand_s;
  logic [PW-1:0] cand_phys_s [3];
  logic          pop_s;
  logic [CW-1:0] avail_s;
  logic [CW-1:0] n_acc_s;
  logic [2:0]    wr_en_s;
  logic [AW-1:0] wr_addr_s [3];
  logic          drop_s;

  // Push candidates in fixed priority order: lane 0, lane 1, squash
  always_comb begin
    cand_s[0]      = bus.commit_valid[0] & bus.commit_has_dest[0];
    cand_s[1]      = bus.commit_valid[1] & bus.commit_has_dest[1];
    cand_s[2]      = bus.squash_valid;
    cand_phys_s[0] = bus.commit_old_phys0;
    cand_phys_s[1] = bus.commit_old_phys1;
    cand_phys_s[2] = bus.squash_phys;
  end

  // Slot allocation; the pop frees its slot this edge, so it counts toward room for pushes
  always_comb begin
    pop_s   = (count_r != CNT_ZERO);
    avail_s = CNT_DEPTH - count_r + {{(CW-1){1'b0}}, pop_s};
    n_acc_s = CNT_ZERO;
    drop_s  = 1'b0;
    wr_en_s = 3'b000;
    for (int k = 0; k < 3; k++) begin
      wr_addr_s[k] = tail_r[AW-1:0] + n_acc_s[AW-1:0];
      if (cand_s[k]) begin
        if (n_acc_s < avail_s) begin
          wr_en_s[k] = 1'b1;
          n_acc_s    = n_acc_s + CNT_ONE;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        wr_en_s[k] = 1'b0;
      end
    end
  end

  // Queue storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en_s[k]) begin
        mem_r[wr_addr_s[k]] <= cand_phys_s[k];
      end
    end
  end

  // Pointers, occupancy, registered release port and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r      <= {(AW+1){1'b0}};
      tail_r      <= {(AW+1){1'b0}};
      count_r     <= CNT_ZERO;
      free_en_r   <= 1'b0;
      free_phys_r <= {PW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      head_r      <= head_r + {{AW{1'b0}}, pop_s};
      tail_r      <= tail_r + n_acc_s;
      count_r     <= count_r + n_acc_s - {{(CW-1){1'b0}}, pop_s};
      free_en_r   <= pop_s;
      free_phys_r <= pop_s ? mem_r[head_r[AW-1:0]] : {PW{1'b0}};
      overflow_r  <= overflow_r | drop_s;
    end
  end

  assign bus.in_ready  = (CNT_DEPTH - count_r) >= CNT_THREE;
  assign bus.free_en   = free_en_r;
  assign bus.free_phys = free_phys_r;
  assign q_count       = count_r;
  assign overflow_err  = overflow_r;

`ifdef RECLAIM_DUPCHK_EN
  logic [PHYS_REGS-1:0] pending_r;
  logic [PHYS_REGS-1:0] pending_next_s;
  logic                 dup_hit_s;
  logic                 dup_r;

  // Pending mask: pop clears the head bit first, so a same-edge re-push leaves it set
  always_comb begin
    pending_next_s = pending_r & ~({{(PHYS_REGS-1){1'b0}}, pop_s} << mem_r[head_r[AW-1:0]]);
    dup_hit_s      = (cand_s[0] & cand_s[1] & (cand_phys_s[0] == cand_phys_s[1]))
                   | (cand_s[0] & cand_s[2] & (cand_phys_s[0] == cand_phys_s[2]))
                   | (cand_s[1] & cand_s[2] & (cand_phys_s[1] == cand_phys_s[2]));
    for (int k = 0; k < 3; k++) begin
      dup_hit_s      = dup_hit_s | (wr_en_s[k] & pending_r[cand_phys_s[k]]);
      pending_next_s = pending_next_s | ({{(PHYS_REGS-1){1'b0}}, wr_en_s[k]} << cand_phys_s[k]);
    end
  end

  // Pending mask and sticky duplicate flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {PHYS_REGS{1'b0}};
      dup_r     <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      dup_r     <= dup_r | dup_hit_s;
    end
  end

  assign dup_err = dup_r;
`endif
endmodule

// File: tb/tb_preg_reclaim_queue.sv
// Directed bench for preg_reclaim_queue: latency, push order, overflow, reset, duplicates.
module tb_preg_reclaim_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] q_count;
  logic       overflow_err;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  preg_reclaim_queue_if #(.PW(6)) bus ();

`ifdef RECLAIM_DUPCHK_EN
  logic dup_err;
  preg_reclaim_queue #(.PHYS_REGS(64), .QDEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .q_count(q_count), .overflow_err(overflow_err), .dup_err(dup_err)
  );
`else
  preg_reclaim_queue #(.PHYS_REGS(64), .QDEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .q_count(q_count), .overflow_err(overflow_err)
  );
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] hd, input logic [5:0] p0,
                       input logic [5:0] p1, input logic sv, input logic [5:0] sp);
    bus.commit_valid     = v;
    bus.commit_has_dest  = hd;
    bus.commit_old_phys0 = p0;
    bus.commit_old_phys1 = p1;
    bus.squash_valid     = sv;
    bus.squash_phys      = sp;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rel(input string tag, input logic [5:0] phys, input logic [4:0] cnt);
    chk({tag, "_en"}, {31'd0, bus.free_en}, 32'd1);
    chk({tag, "_phys"}, {26'd0, bus.free_phys}, {26'd0, phys});
    chk({tag, "_cnt"}, {27'd0, q_count}, {27'd0, cnt});
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_en"}, {31'd0, bus.free_en}, 32'd0);
    chk({tag, "_phys"}, {26'd0, bus.free_phys}, 32'd0);
    chk({tag, "_cnt"}, {27'd0, q_count}, 32'd0);
  endtask

  int exp_q   [9] = '{3, 5, 7, 9, 11, 13, 15, 16, 16};
  int exp_rdy [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int exp_ovf [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    quiet("rst");
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
`ifdef RECLAIM_DUPCHK_EN
    chk("rst_dup", {31'd0, dup_err}, 32'd0);
`endif

    // 1: single lane-0 push, two-edge latency
    drive(2'b01, 2'b01, 6'd7, 6'd0, 1'b0, 6'd0);
    tick();
    chk("t1_push_cnt", {27'd0, q_count}, 32'd1);
    chk("t1_push_en", {31'd0, bus.free_en}, 32'd0);
    idle();
    tick();
    rel("t1_rel", 6'd7, 5'd0);
    tick();
    quiet("t1_done");

    // 2: lane0, lane1, squash in one cycle release in that order
    drive(2'b11, 2'b11, 6'd3, 6'd9, 1'b1, 6'd40);
    tick();
    chk("t2_peak", {27'd0, q_count}, 32'd3);
    idle();
    tick();
    rel("t2_r0", 6'd3, 5'd2);
    tick();
    rel("t2_r1", 6'd9, 5'd1);
    tick();
    rel("t2_r2", 6'd40, 5'd0);
    tick();
    quiet("t2_done");

    // 3: lane 0 valid without a destination is not pushed
    drive(2'b11, 2'b10, 6'd5, 6'd12, 1'b0, 6'd0);
    tick();
    chk("t3_cnt", {27'd0, q_count}, 32'd1);
    idle();
    tick();
    rel("t3_rel", 6'd12, 5'd0);
    tick();
    quiet("t3_done");

    // 6: duplicate register while still queued is released twice
    drive(2'b11, 2'b11, 6'd5, 6'd21, 1'b0, 6'd0);
    tick();
    drive(2'b01, 2'b01, 6'd21, 6'd0, 1'b0, 6'd0);
    tick();
    rel("t6_r0", 6'd5, 5'd2);
    idle();
    tick();
    rel("t6_r1", 6'd21, 5'd1);
    tick();
    rel("t6_r2", 6'd21, 5'd0);
`ifdef RECLAIM_DUPCHK_EN
    chk("t6_dup", {31'd0, dup_err}, 32'd1);
`endif
    tick();
    quiet("t6_done");
    chk("t6_ovf", {31'd0, overflow_err}, 32'd0);

    // 4: three pushes per cycle ignoring in_ready until overflow
    for (int c = 0; c < 9; c++) begin
      drive(2'b11, 2'b11, 6'(3 * c + 1), 6'(3 * c + 2), 1'b1, 6'(3 * c + 3));
      tick();
      chk($sformatf("t4_cnt%0d", c), {27'd0, q_count}, 32'(exp_q[c]));
      chk($sformatf("t4_rdy%0d", c), {31'd0, bus.in_ready}, 32'(exp_rdy[c]));
      chk($sformatf("t4_ovf%0d", c), {31'd0, overflow_err}, 32'(exp_ovf[c]));
      if (c > 0) begin
        chk($sformatf("t4_rel%0d", c), {26'd0, bus.free_phys}, 32'(c));
      end
    end
    idle();
    for (int v = 9; v <= 23; v++) begin
      tick();
      rel($sformatf("t4_drain%0d", v), 6'(v), 5'(24 - v));
    end
    tick();
    rel("t4_last", 6'd25, 5'd0);
    tick();
    quiet("t4_done");
    chk("t4_ovf_sticky", {31'd0, overflow_err}, 32'd1);

    // 5: reset with five entries queued discards them
    drive(2'b11, 2'b11, 6'd1, 6'd2, 1'b1, 6'd3);
    tick();
    tick();
    chk("t5_cnt", {27'd0, q_count}, 32'd5);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    quiet("t5_rst");
    chk("t5_ovf", {31'd0, overflow_err}, 32'd0);
    tick();
    quiet("t5_after");
    tick();
    quiet("t5_after2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
